frame_scanout_controller: RTL and testbench
===========================================

# frame_scanout_controller

Reads the current frame buffer out of SRAM one display row ahead of the VGA beam and presents a 4-bit palette index per pixel to the colour mapper. It is the consumer of the frame buffers that next_frame_controller writes. It shares the SRAM bus with that controller through the graphics_accelerator request/grant arbiter, and ping-pongs between two 160-word line buffers.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per row (4 per SRAM word, so 160 words).
- V_VISIBLE, 480, visible rows.
- V_LAST, 524, last DrawY value of a frame.

Ports:
- Clk  in  1  system clock; the VGA pixel rate is Clk/2.
- Reset  in  1  synchronous, active-high.
- even_frame  in  1  current-frame select from next_frame_controller.
- DrawX  in  10  beam column from the VGA controller.
- DrawY  in  10  beam row from the VGA controller.
- bus_req  out  1  SRAM bus request to graphics_accelerator.
- bus_grant  in  1  SRAM bus granted. Once raised, it is held high until bus_req falls.
- SRAM_ADDRESS  out  20  read address, driven only while granted; 0 otherwise.
- SRAM_OE_N  out  1  read enable, active low.
- SRAM_WE_N  out  1  tied to 1; this block never writes SRAM.
- Data_from_SRAM  in  16  read data.
- pixel_index  out  4  palette index for (DrawX, DrawY), registered.
- underrun  out  1  one-cycle pulse when a row fetch is aborted or missed.

## Operation
- Trigger: new_line is the first Clk cycle with DrawX==0 whose previous-cycle DrawX!=0, using a registered copy of DrawX.
- Fetch row on new_line:
  - DrawY<V_VISIBLE-1: fetch row DrawY+1.
  - DrawY==V_LAST: fetch row 0.
  - Otherwise: no fetch.
- Frame latch: when a fetch of row 0 starts, frame_sel<=even_frame. A buffer swap mid-frame therefore never tears.
- Buffer select: row[0] selects the destination buffer for a fetch; display reads buffer DrawY[0].
- Address: {1'b0, frame_sel, row[9:0], word[7:0]}, with word 0..159.
- Pixel packing: pixel p of a word occupies bits [4p+3:4p], so DrawX[1:0] selects the nibble.
- Valid bits:
  - Each buffer has a valid bit, cleared at fetch start and set when word 159 is stored.
  - If the displayed buffer is invalid, or DrawX>=H_VISIBLE, or DrawY>=V_VISIBLE, pixel_index=0.
- State machine:
  - IDLE: on a fetch trigger, clear the destination valid bit, set word=0 and go to REQ.
  - REQ: bus_req=1. When bus_grant=1, go to RD0.
  - RD0: OE_N=0, address driven; go to RD1.
  - RD1: OE_N=0; go to RD2.
  - RD2: OE_N=0, store Data_from_SRAM to buf[sel][word].
    - word==159: set valid and go to REL.
    - Otherwise: word+1, go to RD0.
  - REL: bus_req=0 for one cycle, then IDLE.
- bus_req is 1 in REQ through RD2 and 0 in IDLE and REL.
- Word counter is 8 bits and never exceeds 159; the row register is 10 bits.
- Overlap rule: a fetch trigger arriving in any state other than IDLE:
  - pulses underrun;
  - abandons the current fetch, leaving its buffer invalid;
  - restarts in REQ for the new row, keeping bus_req high with no REL cycle.
- Reset mid-fetch: bus_req and OE_N deassert on the next edge. The arbiter must see bus_req low within one cycle.

## Timing
- Reset values:
  - state=IDLE, bus_req=0, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_ADDRESS=0;
  - pixel_index=0, underrun=0, both valid bits=0, frame_sel=0.
- Line buffer contents are not reset.
- pixel_index latency: 1 Clk after DrawX/DrawY are presented.
- Per word: 3 cycles after grant. A full row takes 480 cycles after grant plus 1 REL cycle.
- Row budget: 1600 Clk per row (800 pixels × 2), leaving 1119 cycles of grant latency before an underrun.
- A store in RD2 to the buffer not being displayed is visible to pixel_index on the next cycle, once valid is set.

## Test plan
- Reset with DrawX=100, DrawY=10 -> pixel_index=0, bus_req=0, OE_N=1 on every cycle.
- SRAM model fills frame 0 with 16'h4321 per word; grant is immediate; beam runs from DrawY=524 -> row 0 fetch:
  - addresses 0x00000..0x0009F, 3 cycles apart;
  - during row 0, DrawX=0,1,2,3 give pixel_index 1,2,3,4.
- even_frame=1 toggled mid-frame at DrawY=200 -> rows 201..479 still read with bit18=0; the next row-0 fetch reads 0x40000.
- bus_grant withheld for 2000 cycles after the row-5 request -> underrun pulses once at the next new_line; row 5 displays pixel_index=0; row 6 fetches normally.
- DrawX>=640 or DrawY=490 -> pixel_index=0, and no fetch is triggered at new_line for DrawY 479..523.
- Reset asserted in RD1 -> next cycle: bus_req=0, OE_N=1, state IDLE; the next trigger refetches cleanly.

Source files
------------

// File: rtl/frame_scanout_controller.sv
// frame_scanout_controller
// Prefetches the next display row from SRAM into one of two ping-pong line
// buffers while the other buffer feeds 4-bit palette indices to the beam.
//
// Bus handshake: bus_req is raised to ask the arbiter for the SRAM bus and
// stays high for the whole fetch; bus_grant, once raised, stays high until
// bus_req falls. Reads are only issued (SRAM_OE_N low, address driven) in
// the cycles after grant has been seen. Dropping bus_req for one cycle (REL)
// hands the bus back.
module frame_scanout_controller #(
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480,
   parameter int V_LAST    = 524
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        even_frame,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        bus_req,
   input  logic        bus_grant,
   output logic [19:0] SRAM_ADDRESS,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   input  logic [15:0] Data_from_SRAM,
   output logic [3:0]  pixel_index,
   output logic        underrun,
   output logic [2:0]  state_dbg
);

   localparam int         WORDS        = H_VISIBLE / 4;
   localparam logic [7:0] LAST_WORD    = 8'(WORDS - 1);
   localparam logic [9:0] X_LIMIT      = 10'(H_VISIBLE);
   localparam logic [9:0] Y_LIMIT      = 10'(V_VISIBLE);
   localparam logic [9:0] Y_LAST_FETCH = 10'(V_VISIBLE - 1);
   localparam logic [9:0] Y_WRAP       = 10'(V_LAST);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RD0  = 3'd2,
      RD1  = 3'd3,
      RD2  = 3'd4,
      REL  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  word_q, word_d;
   logic [9:0]  row_q, row_d;
   logic        frame_sel_q, frame_sel_d;
   logic [1:0]  valid_q, valid_d;
   logic [9:0]  drawx_prev_q, drawx_prev_d;
   logic        bus_req_q, bus_req_d;
   logic        oe_n_q, oe_n_d;
   logic [19:0] addr_q, addr_d;
   logic [3:0]  pixel_q, pixel_d;
   logic        underrun_q, underrun_d;

   logic        new_line;
   logic        fetch_trig;
   logic [9:0]  fetch_row;
   logic        buf_we;
   logic        rd_phase;

   // Line buffers are plain storage; their contents are qualified by valid_q.
   logic [15:0] line_buf [2][WORDS];

   // Detect the start of a beam line and decide which row (if any) to fetch.
   always_comb begin
      new_line   = (DrawX == 10'd0) && (drawx_prev_q != 10'd0);
      fetch_trig = 1'b0;
      fetch_row  = '0;
      if (new_line) begin
         if (DrawY < Y_LAST_FETCH) begin
            fetch_trig = 1'b1;
            fetch_row  = DrawY + 10'd1;
         end else if (DrawY == Y_WRAP) begin
            fetch_trig = 1'b1;
            fetch_row  = '0;
         end
      end
      drawx_prev_d = DrawX;
   end

   // Fetch state machine next-state logic, including overlap restart.
   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      row_d       = row_q;
      frame_sel_d = frame_sel_q;
      valid_d     = valid_q;
      underrun_d  = 1'b0;
      buf_we      = 1'b0;

      unique case (state_q)
         IDLE: ;
         REQ: begin
            if (bus_grant) state_d = RD0;
         end
         RD0: state_d = RD1;
         RD1: state_d = RD2;
         RD2: begin
            buf_we = 1'b1;
            if (word_q == LAST_WORD) begin
               valid_d[row_q[0]] = 1'b1;
               state_d           = REL;
            end else begin
               word_d  = word_q + 8'd1;
               state_d = RD0;
            end
         end
         REL: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A new trigger always wins: any fetch still in flight is abandoned
      // and its buffer stays invalid; bus_req is kept high (no REL).
      if (fetch_trig) begin
         underrun_d             = (state_q != IDLE);
         buf_we                 = 1'b0;
         valid_d                = valid_q;
         valid_d[fetch_row[0]]  = 1'b0;
         word_d                 = '0;
         row_d                  = fetch_row;
         if (fetch_row == 10'd0) frame_sel_d = even_frame;
         state_d                = REQ;
      end

      rd_phase  = (state_d == RD0) || (state_d == RD1) || (state_d == RD2);
      bus_req_d = rd_phase || (state_d == REQ);
      oe_n_d    = !rd_phase;
      addr_d    = rd_phase ? {1'b0, frame_sel_d, row_d, word_d} : 20'd0;
   end

   // Pixel lookup from the buffer matching the displayed row's parity.
   always_comb begin
      logic        disp;
      logic [7:0]  rd_idx;
      logic [15:0] rd_word;
      disp    = DrawY[0];
      rd_idx  = (DrawX < X_LIMIT) ? DrawX[9:2] : 8'd0;
      rd_word = line_buf[disp][rd_idx];
      pixel_d = 4'd0;
      if ((DrawX < X_LIMIT) && (DrawY < Y_LIMIT) && valid_q[disp])
         pixel_d = rd_word[{DrawX[1:0], 2'b00} +: 4];
   end

   // State, registered outputs and beam tracking.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         word_q       <= '0;
         row_q        <= '0;
         frame_sel_q  <= 1'b0;
         valid_q      <= '0;
         drawx_prev_q <= '0;
         bus_req_q    <= 1'b0;
         oe_n_q       <= 1'b1;
         addr_q       <= '0;
         pixel_q      <= '0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         row_q        <= row_d;
         frame_sel_q  <= frame_sel_d;
         valid_q      <= valid_d;
         drawx_prev_q <= drawx_prev_d;
         bus_req_q    <= bus_req_d;
         oe_n_q       <= oe_n_d;
         addr_q       <= addr_d;
         pixel_q      <= pixel_d;
         underrun_q   <= underrun_d;
      end
   end

   // Capture the read word in RD2 into the destination buffer.
   always_ff @(posedge Clk) begin
      if (buf_we && !Reset) line_buf[row_q[0]][word_q] <= Data_from_SRAM;
   end

   assign bus_req      = bus_req_q;
   assign SRAM_ADDRESS = addr_q;
   assign SRAM_OE_N    = oe_n_q;
   assign SRAM_WE_N    = 1'b1;
   assign pixel_index  = pixel_q;
   assign underrun     = underrun_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_frame_scanout_controller.sv
// Bench for frame_scanout_controller: SRAM content is a pure function of the
// address, the reference keeps whole-row copies of what each line buffer
// should hold, and the beam is driven one compressed line at a time.
module tb_frame_scanout_controller;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD1  = 3'd3;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        even_frame;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        bus_req;
   logic        bus_grant;
   logic [19:0] SRAM_ADDRESS;
   logic        SRAM_OE_N;
   logic        SRAM_WE_N;
   logic [15:0] Data_from_SRAM;
   logic [3:0]  pixel_index;
   logic        underrun;
   logic [2:0]  state_dbg;

   logic        grant_en   = 1'b0;
   logic        const_mode = 1'b1;
   logic [31:0] salt       = 32'd0;

   int n_checks = 0;
   int n_pass   = 0;

   // clock / reset
   always #5 Clk = ~Clk;

   frame_scanout_controller dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .even_frame     (even_frame),
      .DrawX          (DrawX),
      .DrawY          (DrawY),
      .bus_req        (bus_req),
      .bus_grant      (bus_grant),
      .SRAM_ADDRESS   (SRAM_ADDRESS),
      .SRAM_OE_N      (SRAM_OE_N),
      .SRAM_WE_N      (SRAM_WE_N),
      .Data_from_SRAM (Data_from_SRAM),
      .pixel_index    (pixel_index),
      .underrun       (underrun),
      .state_dbg      (state_dbg)
   );

   // SRAM contents: frame 0 holds 16'h4321 everywhere while const_mode is set,
   // otherwise a scrambled function of the address.
   function automatic logic [15:0] mem_word(input logic [19:0] a, input logic cm,
                                            input logic [31:0] s);
      logic [31:0] t;
      if (cm && !a[18]) return 16'h4321;
      t = ({12'h0, a} * 32'h9E3779B1) ^ s;
      return t[31:16];
   endfunction

   assign Data_from_SRAM = SRAM_OE_N ? 16'hdead : mem_word(SRAM_ADDRESS, const_mode, salt);
   assign bus_grant      = bus_req & grant_en;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // reference model: what each line buffer should hold
   logic [15:0] mdl_buf [2][160];
   logic        mdl_valid [2];
   logic        mdl_frame;
   logic        mdl_busy;
   int          ur_expected = 0;
   logic [19:0] last_first_addr;

   function automatic logic [3:0] exp_pix(input logic [9:0] x, input logic [9:0] y);
      logic [15:0] w;
      if (x >= 10'd640 || y >= 10'd480 || !mdl_valid[y[0]]) return 4'd0;
      w = mdl_buf[y[0]][x[9:2]];
      return w[x[1:0]*4 +: 4];
   endfunction

   // bus monitor / scoreboard inputs
   logic [19:0] exp_q[$];
   logic [19:0] obs_addr_q[$];
   int          obs_cyc_q[$];
   int          cyc         = 0;
   logic        prev_oe_n   = 1'b1;
   logic [19:0] prev_addr   = 20'd0;
   int          idle_addr_bad = 0;
   int          we_bad      = 0;
   int          ur_seen     = 0;
   int          req_cycles  = 0;

   always @(negedge Clk) begin
      cyc++;
      if (SRAM_OE_N === 1'b0 && (prev_oe_n || SRAM_ADDRESS != prev_addr)) begin
         obs_addr_q.push_back(SRAM_ADDRESS);
         obs_cyc_q.push_back(cyc);
      end
      if (SRAM_OE_N === 1'b1 && SRAM_ADDRESS !== 20'd0) idle_addr_bad++;
      if (SRAM_WE_N !== 1'b1) we_bad++;
      if (underrun === 1'b1) ur_seen++;
      if (bus_req === 1'b1) req_cycles++;
      prev_oe_n = SRAM_OE_N;
      prev_addr = SRAM_ADDRESS;
   end

   // One compressed beam line: DrawX goes nonzero then 0 at row y, then
   // random columns are presented and the pixel output is checked each cycle.
   task automatic do_line(input logic [9:0] y, input int cycles, input bit grant_now);
      logic        fetch;
      logic        exp_ur;
      logic [9:0]  row;
      logic [19:0] base;
      logic [15:0] nb [160];
      logic [3:0]  e;
      int          req0, bad, gap_bad;

      DrawX = 10'd799;
      @(posedge Clk); #1;
      DrawY    = y;
      DrawX    = 10'd0;
      grant_en = grant_now;
      obs_addr_q.delete();
      obs_cyc_q.delete();
      exp_q.delete();
      req0  = req_cycles;
      fetch = (y < 10'd479) || (y == 10'd524);
      row   = (y == 10'd524) ? 10'd0 : y + 10'd1;
      base  = 20'd0;
      exp_ur = 1'b0;
      if (fetch) begin
         exp_ur = mdl_busy;
         if (exp_ur) ur_expected++;
         if (row == 10'd0) mdl_frame = even_frame;
         mdl_valid[row[0]] = 1'b0;
         base = {1'b0, mdl_frame, row, 8'h00};
         for (int w = 0; w < 160; w++) begin
            exp_q.push_back(base + 20'(w));
            nb[w] = mem_word(base + 20'(w), const_mode, salt);
         end
         mdl_busy = 1'b1;
      end

      for (int c = 0; c < cycles; c++) begin
         e = exp_pix(DrawX, DrawY);
         @(posedge Clk); #1;
         check("pixel", pixel_index, e);
         if (c == 0) check("underrun_pulse", underrun, exp_ur);
         if (c == 1) check("underrun_single", underrun, 1'b0);
         if (c + 1 < 4) DrawX = 10'(c + 1);
         else           DrawX = 10'($urandom_range(799, 1));
      end

      if (fetch && grant_now) begin
         for (int w = 0; w < 160; w++) mdl_buf[row[0]][w] = nb[w];
         mdl_valid[row[0]] = 1'b1;
         mdl_busy = 1'b0;
         check("addr_count", obs_addr_q.size(), 160);
         bad = 0;
         gap_bad = 0;
         for (int i = 0; i < obs_addr_q.size() && i < exp_q.size(); i++) begin
            if (obs_addr_q[i] !== exp_q[i]) bad++;
            if (i > 0 && obs_cyc_q[i] - obs_cyc_q[i-1] != 3) gap_bad++;
         end
         check("addr_seq", bad, 0);
         check("addr_gap", gap_bad, 0);
         if (obs_addr_q.size() > 0) begin
            last_first_addr = obs_addr_q[0];
            check("addr_first", obs_addr_q[0], base);
            check("addr_last", obs_addr_q[obs_addr_q.size()-1], base + 20'd159);
         end
      end else if (fetch) begin
         check("no_reads_without_grant", obs_addr_q.size(), 0);
      end else if (!mdl_busy) begin
         check("no_fetch_req", req_cycles - req0, 0);
         check("no_fetch_reads", obs_addr_q.size(), 0);
      end
   endtask

   initial begin
      int k;
      for (int w = 0; w < 160; w++) begin
         mdl_buf[0][w] = 16'h0;
         mdl_buf[1][w] = 16'h0;
      end
      mdl_valid[0] = 1'b0;
      mdl_valid[1] = 1'b0;
      mdl_frame    = 1'b0;
      mdl_busy     = 1'b0;
      last_first_addr = 20'd0;

      // reset holds everything quiet regardless of the beam
      Reset      = 1'b1;
      even_frame = 1'b0;
      DrawX      = 10'd100;
      DrawY      = 10'd10;
      for (int c = 0; c < 5; c++) begin
         @(posedge Clk); #1;
         check("rst_pixel", pixel_index, 4'd0);
         check("rst_bus_req", bus_req, 1'b0);
         check("rst_oe_n", SRAM_OE_N, 1'b1);
         check("rst_addr", SRAM_ADDRESS, 20'd0);
         check("rst_underrun", underrun, 1'b0);
         check("rst_state", state_dbg, ST_IDLE);
      end
      Reset = 1'b0;
      salt  = $urandom();

      // row 0 from constant frame 0, then display it
      const_mode = 1'b1;
      do_line(10'd524, 600, 1'b1);
      check("row0_base", last_first_addr, 20'h00000);
      do_line(10'd0, 600, 1'b1);
      const_mode = 1'b0;
      do_line(10'd1, 600, 1'b1);
      do_line(10'd2, 600, 1'b1);
      do_line(10'd3, 600, 1'b1);

      // grant withheld for the row-5 fetch
      do_line(10'd4, 2000, 1'b0);
      do_line(10'd5, 600, 1'b1);
      do_line(10'd6, 600, 1'b1);

      // a few random visible rows
      for (int i = 0; i < 3; i++) do_line(10'($urandom_range(190, 7)), 600, 1'b1);

      // frame select changes mid-frame; only the next row-0 fetch follows it
      do_line(10'd199, 600, 1'b1);
      even_frame = 1'b1;
      do_line(10'd200, 600, 1'b1);
      do_line(10'd201, 600, 1'b1);
      do_line(10'd478, 600, 1'b1);
      do_line(10'd479, 600, 1'b1);
      do_line(10'd490, 600, 1'b1);
      do_line(10'd523, 600, 1'b1);
      do_line(10'd524, 600, 1'b1);
      check("frame1_base", last_first_addr, 20'h40000);
      do_line(10'd0, 600, 1'b1);

      // reset in the middle of a fetch
      DrawX = 10'd799;
      @(posedge Clk); #1;
      DrawY    = 10'd10;
      DrawX    = 10'd0;
      grant_en = 1'b1;
      k = 0;
      while (k < 20 && state_dbg !== ST_RD1) begin
         @(posedge Clk); #1;
         k++;
      end
      check("reach_rd1", state_dbg, ST_RD1);
      Reset = 1'b1;
      @(posedge Clk); #1;
      check("midrst_bus_req", bus_req, 1'b0);
      check("midrst_oe_n", SRAM_OE_N, 1'b1);
      check("midrst_state", state_dbg, ST_IDLE);
      Reset = 1'b0;
      mdl_valid[0] = 1'b0;
      mdl_valid[1] = 1'b0;
      mdl_frame    = 1'b0;
      mdl_busy     = 1'b0;
      do_line(10'd10, 600, 1'b1);
      do_line(10'd11, 600, 1'b1);

      check("underrun_total", ur_seen, ur_expected);
      check("idle_addr_zero", idle_addr_bad, 0);
      check("we_n_high", we_bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
